// File: rtl/tprescaler_pkg.sv
// Shared types and defaults for the timer prescaler datapath.
package tprescaler_pkg;

    typedef enum logic {
        TPRESC_IDLE,
        TPRESC_RUN
    } tpresc_state_e;

    localparam int PRESC_W_DEF  = 8;
    localparam int SYNC_STG_DEF = 2;

endpackage

// File: rtl/tprescaler_sync.sv
// Reference-clock synchronizer with registered rising-edge detect.
// A ref_clk_i rise shows up on evt_edge_o SYNC_STG+1 clk_i cycles later.
module tprescaler_sync
    import tprescaler_pkg::*;
#(
    parameter int SYNC_STG = SYNC_STG_DEF
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic ref_clk_i,
    output logic evt_edge_o
);

    logic [SYNC_STG-1:0] sync_q, sync_d;
    logic                prev_q, prev_d;
    logic                edge_q, edge_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STG-2:0], ref_clk_i};
        prev_d = sync_q[SYNC_STG-1];
        edge_d = sync_q[SYNC_STG-1] & ~prev_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            edge_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            edge_q <= edge_d;
        end
    end

    assign evt_edge_o = edge_q;

endmodule

// File: rtl/tprescaler_core.sv
// Timer prescaler: divides clk_i cycles or ref_clk_i rises by (presc+1), emits tick_o,
// and takes new prescale values through a valid/ready handshake applied at count boundaries.
module tprescaler_core
    import tprescaler_pkg::*;
#(
    parameter int PRESC_W  = PRESC_W_DEF,
    parameter int SYNC_STG = SYNC_STG_DEF
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               enable_i,
    input  logic               clear_i,
    input  logic               ref_sel_i,
    input  logic               ref_clk_i,
    input  logic               cfg_valid_i,
    input  logic [PRESC_W-1:0] cfg_presc_i,
    output logic               cfg_ready_o,
    output logic               tick_o,
    output logic [PRESC_W-1:0] cnt_o,
    output logic [PRESC_W-1:0] presc_o
);

    tpresc_state_e      state_q, state_d;
    logic [PRESC_W-1:0] cnt_q, cnt_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [PRESC_W-1:0] pend_q, pend_d;
    logic               pending_q, pending_d;
    logic               tick_q, tick_d;

    logic ref_edge;
    logic evt;
    logic accept;
    logic terminal;

    // The synchronizer runs regardless of ref_sel_i, so switching source never fakes an edge.
    tprescaler_sync #(
        .SYNC_STG (SYNC_STG)
    ) u_sync (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .ref_clk_i  (ref_clk_i),
        .evt_edge_o (ref_edge)
    );

    assign evt      = ref_sel_i ? ref_edge : 1'b1;
    assign accept   = cfg_valid_i & ~pending_q;
    assign terminal = evt & (cnt_q >= presc_q);

    // NOTE: every next-state signal gets a default first so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        presc_d   = presc_q;
        pend_d    = pend_q;
        pending_d = pending_q;
        tick_d    = 1'b0;

        unique case (state_q)
            TPRESC_IDLE: begin
                if (accept) begin
                    presc_d = cfg_presc_i;
                end
                if (enable_i) begin
                    state_d = TPRESC_RUN;
                end
                cnt_d = '0;
            end

            TPRESC_RUN: begin
                if (!enable_i) begin
                    // Leaving RUN is a count boundary: a held value takes effect now.
                    state_d = TPRESC_IDLE;
                    cnt_d   = '0;
                    if (pending_q) begin
                        presc_d   = pend_q;
                        pending_d = 1'b0;
                    end else if (accept) begin
                        presc_d = cfg_presc_i;
                    end
                end else begin
                    if (clear_i) begin
                        cnt_d = '0;
                    end else if (terminal) begin
                        cnt_d  = '0;
                        tick_d = 1'b1;
                        if (pending_q) begin
                            presc_d   = pend_q;
                            pending_d = 1'b0;
                        end
                    end else if (evt) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    if (accept) begin
                        pend_d    = cfg_presc_i;
                        pending_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = TPRESC_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= TPRESC_IDLE;
            cnt_q     <= '0;
            presc_q   <= '0;
            pend_q    <= '0;
            pending_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            presc_q   <= presc_d;
            pend_q    <= pend_d;
            pending_q <= pending_d;
            tick_q    <= tick_d;
        end
    end

    assign cfg_ready_o = ~pending_q;
    assign tick_o      = tick_q;
    assign cnt_o       = cnt_q;
    assign presc_o     = presc_q;

endmodule

// File: tb/tb_tprescaler_core.sv
// Self-checking bench for tprescaler_core: directed scenarios plus randomized traffic,
// all compared against a behavioural reference model built from the prescaler rules.
module tb_tprescaler_core;

    localparam int W   = 8;
    localparam int STG = 2;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic         enable_i;
    logic         clear_i;
    logic         ref_sel_i;
    logic         ref_clk_i;
    logic         cfg_valid_i;
    logic [W-1:0] cfg_presc_i;
    logic         cfg_ready_o;
    logic         tick_o;
    logic [W-1:0] cnt_o;
    logic [W-1:0] presc_o;

    tprescaler_core #(
        .PRESC_W  (W),
        .SYNC_STG (STG)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .enable_i    (enable_i),
        .clear_i     (clear_i),
        .ref_sel_i   (ref_sel_i),
        .ref_clk_i   (ref_clk_i),
        .cfg_valid_i (cfg_valid_i),
        .cfg_presc_i (cfg_presc_i),
        .cfg_ready_o (cfg_ready_o),
        .tick_o      (tick_o),
        .cnt_o       (cnt_o),
        .presc_o     (presc_o)
    );

    always #5 clk_i = ~clk_i;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model state: plain integers plus a history of ref_clk_i samples.
    bit m_run;
    bit m_pending;
    bit m_tick;
    int m_cnt;
    int m_presc;
    int m_pend;
    bit rq[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_run     = 1'b0;
        m_pending = 1'b0;
        m_tick    = 1'b0;
        m_cnt     = 0;
        m_presc   = 0;
        m_pend    = 0;
        rq.delete();
        for (int i = 0; i < STG + 2; i++) rq.push_back(1'b0);
    endtask

    // One clock: capture the inputs seen at the edge, advance the model, compare 1 time unit later.
    task automatic cycle();
        bit evt, acc, en, clr, sel, vld, r;
        int cfg;
        en  = enable_i;
        clr = clear_i;
        sel = ref_sel_i;
        vld = cfg_valid_i;
        r   = ref_clk_i;
        cfg = int'(cfg_presc_i);
        // A ref rise sampled at edge k is usable as an event in the cycle after edge k+STG.
        evt = sel ? (rq[rq.size()-1-STG] && !rq[rq.size()-2-STG]) : 1'b1;
        acc = vld && !m_pending;
        @(posedge clk_i);
        rq.push_back(r);
        if (rq.size() > STG + 2) void'(rq.pop_front());
        m_tick = 1'b0;
        if (!m_run) begin
            if (acc) m_presc = cfg;
            if (en) m_run = 1'b1;
            m_cnt = 0;
        end else if (!en) begin
            m_run = 1'b0;
            m_cnt = 0;
            if (m_pending) begin
                m_presc   = m_pend;
                m_pending = 1'b0;
            end else if (acc) begin
                m_presc = cfg;
            end
        end else begin
            if (clr) begin
                m_cnt = 0;
            end else if (evt) begin
                if (m_cnt == m_presc) begin
                    m_cnt  = 0;
                    m_tick = 1'b1;
                    if (m_pending) begin
                        m_presc   = m_pend;
                        m_pending = 1'b0;
                    end
                end else begin
                    m_cnt = m_cnt + 1;
                end
            end
            if (acc) begin
                m_pend    = cfg;
                m_pending = 1'b1;
            end
        end
        #1;
        chk("cnt",   cnt_o,       m_cnt);
        chk("presc", presc_o,     m_presc);
        chk("tick",  tick_o,      m_tick);
        chk("ready", cfg_ready_o, !m_pending);
    endtask

    // Go to IDLE, load a prescale value directly, then enter RUN with the given source.
    task automatic restart(input int presc, input bit sel);
        enable_i    = 1'b0;
        clear_i     = 1'b0;
        ref_sel_i   = sel;
        ref_clk_i   = 1'b0;
        cycle();
        cfg_valid_i = 1'b1;
        cfg_presc_i = W'(presc);
        cycle();
        cfg_valid_i = 1'b0;
        enable_i    = 1'b1;
        cycle();
    endtask

    initial begin
        int ticks;
        int waited;
        rst_ni      = 1'b0;
        enable_i    = 1'b0;
        clear_i     = 1'b0;
        ref_sel_i   = 1'b0;
        ref_clk_i   = 1'b0;
        cfg_valid_i = 1'b0;
        cfg_presc_i = '0;
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_cnt",   cnt_o,       0);
        chk("rst_presc", presc_o,     0);
        chk("rst_tick",  tick_o,      0);
        chk("rst_ready", cfg_ready_o, 1);
        rst_ni = 1'b1;

        // Divide-by-4 on clk_i: three ticks in twelve cycles.
        restart(3, 1'b0);
        ticks = 0;
        for (int i = 0; i < 12; i++) begin
            cycle();
            ticks += int'(tick_o);
        end
        chk("div4_ticks", ticks, 3);

        // presc=0 on clk_i: tick held high, counter held at zero.
        restart(0, 1'b0);
        ticks = 0;
        for (int i = 0; i < 6; i++) begin
            cycle();
            ticks += int'(tick_o);
        end
        chk("p0_ticks", ticks, 6);
        chk("p0_cnt", cnt_o, 0);

        // New value offered mid-count becomes pending until the terminal count.
        restart(9, 1'b0);
        repeat (4) cycle();
        chk("pend_cnt_before", cnt_o, 4);
        cfg_valid_i = 1'b1;
        cfg_presc_i = 8'd2;
        cycle();
        cfg_valid_i = 1'b0;
        chk("pend_ready_low", cfg_ready_o, 0);
        chk("pend_presc_old", presc_o, 9);
        waited = 0;
        while (tick_o !== 1'b1 && waited < 20) begin
            cycle();
            waited++;
        end
        chk("pend_tick_seen", tick_o, 1);
        chk("pend_presc_new", presc_o, 2);
        repeat (2) cycle();
        chk("pend_no_tick_early", tick_o, 0);
        cycle();
        chk("pend_next_tick", tick_o, 1);

        // External reference, period 10 clk, presc=1: first event 3 clk after the rise.
        restart(1, 1'b1);
        ticks = 0;
        for (int i = 0; i < 60; i++) begin
            ref_clk_i = (i % 10) < 5;
            cycle();
            ticks += int'(tick_o);
            if (i == 2) chk("ref_no_evt_yet", cnt_o, 0);
            if (i == 3) chk("ref_first_evt", cnt_o, 1);
        end
        chk("ref_ticks", ticks, 3);
        ref_clk_i = 1'b0;

        // Clear on the terminal-count cycle suppresses the tick.
        restart(5, 1'b0);
        repeat (5) cycle();
        chk("clr_cnt_at_term", cnt_o, 5);
        clear_i = 1'b1;
        cycle();
        clear_i = 1'b0;
        chk("clr_tick", tick_o, 0);
        chk("clr_cnt", cnt_o, 0);
        for (int i = 0; i < 6; i++) begin
            cycle();
            chk("clr_next_tick", tick_o, (i == 5) ? 1 : 0);
        end

        // Asynchronous reset mid-count with a pending value held.
        restart(9, 1'b0);
        repeat (6) cycle();
        cfg_valid_i = 1'b1;
        cfg_presc_i = 8'd3;
        cycle();
        cfg_valid_i = 1'b0;
        chk("arst_cnt_before", cnt_o, 7);
        chk("arst_pending", cfg_ready_o, 0);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("arst_cnt",   cnt_o,       0);
        chk("arst_presc", presc_o,     0);
        chk("arst_ready", cfg_ready_o, 1);
        chk("arst_tick",  tick_o,      0);
        model_reset();
        enable_i = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        cycle();

        // Randomized traffic against the model.
        enable_i = 1'b1;
        for (int i = 0; i < 700; i++) begin
            enable_i    = ($urandom_range(0, 29) != 0);
            clear_i     = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 49) == 0) ref_sel_i = ~ref_sel_i;
            if ($urandom_range(0, 5) == 0) ref_clk_i = ~ref_clk_i;
            cfg_valid_i = enable_i && ($urandom_range(0, 3) == 0);
            cfg_presc_i = ($urandom_range(0, 9) == 0) ? W'($urandom) : W'($urandom_range(0, 6));
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
